// File: rtl/moore_101_detector.sv
// Moore FSM that flags each "101" seen on a serial input stream.
// With OVERLAP=1 the final 1 of a match may start the next match.
module moore_101_detector #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic x,
    output logic y
);

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE = 2'b00;
    localparam logic [STATE_W-1:0] S_1    = 2'b01;
    localparam logic [STATE_W-1:0] S_10   = 2'b10;
    localparam logic [STATE_W-1:0] S_101  = 2'b11;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               y_q;
    logic               y_d;

    // State and output registers; synchronous reset wins over the transition logic.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    // Next-state logic; y is registered from the next state so it equals (state_q == S_101).
    always_comb begin
        state_d = S_IDLE;
        y_d     = 1'b0;
        case (state_q)
            S_IDLE:  state_d = x ? S_1 : S_IDLE;
            S_1:     state_d = x ? S_1 : S_10;
            S_10:    state_d = x ? S_101 : S_IDLE;
            S_101: begin
                if (x) begin
                    state_d = S_1;
                end else begin
                    state_d = OVERLAP ? S_10 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        y_d = (state_d == S_101);
    end

    assign y = y_q;

endmodule

// File: tb/tb_moore_101_detector.sv
// Bench for moore_101_detector: overlapping and non-overlapping instances
// checked every cycle against a bit-history model, plus literal pulse positions.
module tb_moore_101_detector;

    logic clk;
    logic reset_n;
    logic x;
    logic y_ov;
    logic y_no;

    int checks;
    int passed;

    // Model: bits sampled since reset (overlap) / since reset or last match (non-overlap).
    int   hist_ov[$];
    int   hist_no[$];
    logic exp_ov;
    logic exp_no;
    logic model_valid;

    moore_101_detector #(.OVERLAP(1'b1)) u_ov (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .y       (y_ov)
    );

    moore_101_detector #(.OVERLAP(1'b0)) u_no (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .y       (y_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit ends_with_101(input int h[$]);
        int n;
        n = h.size();
        if (n < 3) return 1'b0;
        return (h[n-3] == 1) && (h[n-2] == 0) && (h[n-1] == 1);
    endfunction

    // Apply one sampled bit, advance the model, then compare both DUTs 1 time unit later.
    task automatic step(input logic r, input int b);
        reset_n = r;
        x       = (b != 0);
        @(posedge clk);
        if (!r) begin
            hist_ov.delete();
            hist_no.delete();
            exp_ov      = 1'b0;
            exp_no      = 1'b0;
            model_valid = 1'b1;
        end else begin
            hist_ov.push_back(b != 0 ? 1 : 0);
            hist_no.push_back(b != 0 ? 1 : 0);
            exp_ov = ends_with_101(hist_ov);
            exp_no = ends_with_101(hist_no);
            if (exp_no) hist_no.delete();
        end
        #1;
        if (model_valid) begin
            check("y_overlap", int'(y_ov), int'(exp_ov));
            check("y_nonoverlap", int'(y_no), int'(exp_no));
        end
    endtask

    task automatic check_list(input string name, input int got[$], input int req[$]);
        int n;
        check({name, "_count"}, got.size(), req.size());
        n = (got.size() < req.size()) ? got.size() : req.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_index"}, got[i], req[i]);
        end
    endtask

    // Reset, then drive bits; index rst_at (if >= 0) is a reset edge instead of data.
    task automatic run_seg(input string name, input int bits[$], input int rst_at,
                           input int lit_ov[$], input int lit_no[$]);
        int eo[$];
        int en[$];
        int dov[$];
        int dno[$];
        step(1'b0, 0);
        foreach (bits[i]) begin
            step((i == rst_at) ? 1'b0 : 1'b1, bits[i]);
            if (exp_ov) eo.push_back(i);
            if (exp_no) en.push_back(i);
            if (y_ov === 1'b1) dov.push_back(i);
            if (y_no === 1'b1) dno.push_back(i);
        end
        check_list({name, "_model_ov"}, eo, lit_ov);
        check_list({name, "_model_no"}, en, lit_no);
        check_list({name, "_dut_ov"}, dov, lit_ov);
        check_list({name, "_dut_no"}, dno, lit_no);
    endtask

    initial begin
        int seq[$];
        int lov[$];
        int lno[$];
        checks      = 0;
        passed      = 0;
        model_valid = 1'b0;
        exp_ov      = 1'b0;
        exp_no      = 1'b0;
        reset_n     = 1'b0;
        x           = 1'b0;

        // Reset held with x toggling, then released with x held low.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, i % 2);
            check("reset_y_ov", int'(y_ov), 0);
            check("reset_y_no", int'(y_no), 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 0);
            check("idle_y_ov", int'(y_ov), 0);
        end

        seq = '{1, 0, 1, 0};
        lov = '{2};
        lno = '{2};
        run_seg("basic", seq, -1, lov, lno);

        seq = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0};
        lov = '{7, 9, 13, 19};
        lno = '{7, 13, 19};
        run_seg("long", seq, -1, lov, lno);

        seq = '{1, 0, 1, 0, 1, 0};
        lov = '{2, 4};
        lno = '{2};
        run_seg("b2b", seq, -1, lov, lno);

        // Prefix "10" discarded by reset; x=1 on the reset edge is ignored.
        seq = '{1, 0, 1, 1, 0, 1, 0};
        lov = '{5};
        lno = '{5};
        run_seg("mid_reset", seq, 2, lov, lno);

        // Reset while y is high clears it on the next edge.
        seq = '{1, 0, 1, 0, 1};
        lov = '{2};
        lno = '{2};
        run_seg("reset_in_match", seq, 3, lov, lno);

        seq = '{1, 1, 0, 0, 1, 0, 0};
        lov = {};
        lno = {};
        run_seg("near_miss", seq, -1, lov, lno);

        seq = '{1, 1, 1, 0, 0, 1, 1, 1};
        lov = {};
        lno = {};
        run_seg("runs", seq, -1, lov, lno);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
